// File: rtl/insbundle_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : insbundle_queue                                            |
// | Description : Decoded-bundle FIFO between the frontend and rename.       |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module insbundle_queue #(
    parameter int DEPTH    = 8,
    parameter int BUNDLE_W = 235
) (
    input  logic                      cpu_clock_i,
    input  logic                      reset_ni,
    input  logic                      flush_i,
    input  logic                      enq_valid_i,
    input  logic                      enq_ins1_valid_i,
    input  logic [BUNDLE_W-1:0]       enq_bundle_i,
    output logic                      enq_busy_o,
    output logic                      deq_valid_o,
    output logic                      deq_ins1_valid_o,
    output logic [BUNDLE_W-1:0]       deq_bundle_o,
    input  logic                      deq_busy_i,
    output logic [$clog2(DEPTH):0]    count_o
);

    localparam int c_IDX_W   = $clog2(DEPTH);
    localparam int c_PTR_W   = c_IDX_W + 1;
    localparam int c_ENTRY_W = BUNDLE_W + 1;

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("insbundle_queue: DEPTH must be a power of two and at least 2");
    end

    logic [c_PTR_W-1:0]   head_q;
    logic [c_PTR_W-1:0]   head_d;
    logic [c_PTR_W-1:0]   tail_q;
    logic [c_PTR_W-1:0]   tail_d;
    logic [c_ENTRY_W-1:0] mem_q [DEPTH];

    logic                 w_full;
    logic                 w_empty;
    logic                 w_enq_fire;
    logic                 w_deq_fire;
    logic [c_ENTRY_W-1:0] w_head_entry;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign w_empty = (head_q == tail_q);
    assign w_full  = (head_q[c_IDX_W-1:0] == tail_q[c_IDX_W-1:0]) &&
                     (head_q[c_IDX_W] != tail_q[c_IDX_W]);

    assign w_enq_fire = enq_valid_i && !w_full && !flush_i;
    assign w_deq_fire = !w_empty && !deq_busy_i && !flush_i;

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        if (flush_i) begin
            head_d = '0;
            tail_d = '0;
        end else begin
            if (w_enq_fire) begin
                tail_d = tail_q + c_PTR_W'(1);
            end
            if (w_deq_fire) begin
                head_d = head_q + c_PTR_W'(1);
            end
        end
    end

    always_ff @(posedge cpu_clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    // Payload storage is deliberately left unreset; validity comes from the pointers.
    always_ff @(posedge cpu_clock_i) begin
        if (w_enq_fire) begin
            mem_q[tail_q[c_IDX_W-1:0]] <= {enq_ins1_valid_i, enq_bundle_i};
        end
    end

    assign w_head_entry     = mem_q[head_q[c_IDX_W-1:0]];
    assign deq_bundle_o     = w_head_entry[BUNDLE_W-1:0];
    assign deq_ins1_valid_o = !w_empty && w_head_entry[BUNDLE_W];
    assign deq_valid_o      = !w_empty;
    assign enq_busy_o       = w_full;
    assign count_o          = tail_q - head_q;

endmodule
`default_nettype wire

// File: tb/tb_insbundle_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_insbundle_queue                                         |
// | Description : Directed self-checking bench for insbundle_queue.          |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module tb_insbundle_queue;

    localparam int DEPTH = 8;
    localparam int BW    = 235;

    logic          cpu_clock_i;
    logic          reset_ni;
    logic          flush_i;
    logic          enq_valid_i;
    logic          enq_ins1_valid_i;
    logic [BW-1:0] enq_bundle_i;
    logic          enq_busy_o;
    logic          deq_valid_o;
    logic          deq_ins1_valid_o;
    logic [BW-1:0] deq_bundle_o;
    logic          deq_busy_i;
    logic [3:0]    count_o;

    int checks;
    int errors;

    insbundle_queue #(.DEPTH(DEPTH), .BUNDLE_W(BW)) u_dut (
        .cpu_clock_i      (cpu_clock_i),
        .reset_ni         (reset_ni),
        .flush_i          (flush_i),
        .enq_valid_i      (enq_valid_i),
        .enq_ins1_valid_i (enq_ins1_valid_i),
        .enq_bundle_i     (enq_bundle_i),
        .enq_busy_o       (enq_busy_o),
        .deq_valid_o      (deq_valid_o),
        .deq_ins1_valid_o (deq_ins1_valid_o),
        .deq_bundle_o     (deq_bundle_o),
        .deq_busy_i       (deq_busy_i),
        .count_o          (count_o)
    );

    initial cpu_clock_i = 1'b0;
    always #5 cpu_clock_i = ~cpu_clock_i;

    task automatic tick();
        @(posedge cpu_clock_i);
        #1;
    endtask

    task automatic test_reset();
        checks++;
        if (count_o !== 4'd0) begin
            errors++; $display("FAIL reset_count: got %0d expected 0", count_o);
        end
        checks++;
        if ({deq_valid_o, enq_busy_o, deq_ins1_valid_o} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: got valid=%b busy=%b ins1=%b expected 0 0 0",
                     deq_valid_o, enq_busy_o, deq_ins1_valid_o);
        end
    endtask

    task automatic test_single();
        deq_busy_i = 1'b1; enq_valid_i = 1'b1; enq_ins1_valid_i = 1'b1;
        enq_bundle_i = 235'h1234;
        tick();
        enq_valid_i = 1'b0;
        checks++;
        if ({deq_valid_o, deq_ins1_valid_o} !== 2'b11 || deq_bundle_o !== 235'h1234
            || count_o !== 4'd1) begin
            errors++;
            $display("FAIL single_enq: got valid=%b ins1=%b bundle=%0h count=%0d expected 1 1 1234 1",
                     deq_valid_o, deq_ins1_valid_o, deq_bundle_o, count_o);
        end
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        checks++;
        if (count_o !== 4'd0 || deq_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL single_flush: got count=%0d valid=%b expected 0 0", count_o, deq_valid_o);
        end
    endtask

    task automatic test_fill();
        deq_busy_i = 1'b1;
        for (int i = 1; i <= DEPTH; i++) begin
            enq_valid_i = 1'b1; enq_ins1_valid_i = i[0]; enq_bundle_i = BW'(i);
            tick();
            checks++;
            if (count_o !== 4'(i)) begin
                errors++; $display("FAIL fill_count: got %0d expected %0d", count_o, i);
            end
        end
        checks++;
        if (enq_busy_o !== 1'b1) begin
            errors++; $display("FAIL fill_busy: got %b expected 1", enq_busy_o);
        end
        enq_bundle_i = BW'(9); enq_ins1_valid_i = 1'b0;
        tick();
        checks++;
        if (count_o !== 4'd8 || deq_bundle_o !== BW'(1) || deq_ins1_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL full_offer: got count=%0d head=%0h ins1=%b expected 8 1 1",
                     count_o, deq_bundle_o, deq_ins1_valid_o);
        end
        enq_valid_i = 1'b0; deq_busy_i = 1'b0;
        for (int i = 1; i <= DEPTH; i++) begin
            checks++;
            if (deq_valid_o !== 1'b1 || deq_bundle_o !== BW'(i) || deq_ins1_valid_o !== i[0]) begin
                errors++;
                $display("FAIL drain_order: got valid=%b bundle=%0h ins1=%b expected 1 %0h %b",
                         deq_valid_o, deq_bundle_o, deq_ins1_valid_o, i, i[0]);
            end
            tick();
        end
        checks++;
        if (deq_valid_o !== 1'b0 || count_o !== 4'd0) begin
            errors++;
            $display("FAIL drain_empty: got valid=%b count=%0d expected 0 0", deq_valid_o, count_o);
        end
    endtask

    task automatic test_stream();
        enq_valid_i = 1'b1; deq_busy_i = 1'b0; enq_ins1_valid_i = 1'b0;
        for (int k = 0; k < 20; k++) begin
            enq_bundle_i = BW'(k);
            tick();
            checks++;
            if (count_o !== 4'd1 || deq_bundle_o !== BW'(k)) begin
                errors++;
                $display("FAIL stream: got count=%0d bundle=%0h expected 1 %0h", count_o, deq_bundle_o, k);
            end
        end
        enq_valid_i = 1'b0;
        tick();
        checks++;
        if (deq_valid_o !== 1'b0) begin
            errors++; $display("FAIL stream_end: got valid=%b expected 0", deq_valid_o);
        end
    endtask

    task automatic test_flush_full();
        deq_busy_i = 1'b1; enq_valid_i = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            enq_bundle_i = BW'(32'hA0 + i);
            tick();
        end
        checks++;
        if (enq_busy_o !== 1'b1) begin
            errors++; $display("FAIL flush_pre_full: got busy=%b expected 1", enq_busy_o);
        end
        flush_i = 1'b1; deq_busy_i = 1'b0; enq_bundle_i = 235'hDEAD;
        tick();
        flush_i = 1'b0; enq_valid_i = 1'b0;
        checks++;
        if (count_o !== 4'd0 || deq_valid_o !== 1'b0 || enq_busy_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_full: got count=%0d valid=%b busy=%b expected 0 0 0",
                     count_o, deq_valid_o, enq_busy_o);
        end
        tick();
        checks++;
        if (deq_valid_o !== 1'b0 || count_o !== 4'd0) begin
            errors++;
            $display("FAIL empty_idle: got valid=%b count=%0d expected 0 0", deq_valid_o, count_o);
        end
        deq_busy_i = 1'b1; enq_valid_i = 1'b1; enq_bundle_i = 235'h55;
        tick();
        enq_valid_i = 1'b0;
        checks++;
        if (deq_bundle_o !== 235'h55 || count_o !== 4'd1) begin
            errors++;
            $display("FAIL post_flush: got bundle=%0h count=%0d expected 55 1", deq_bundle_o, count_o);
        end
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
    endtask

    task automatic test_simultaneous();
        logic [BW-1:0] exp_q [$];
        deq_busy_i = 1'b1; enq_valid_i = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            enq_bundle_i = BW'(32'h30 + i);
            tick();
        end
        enq_bundle_i = 235'h34; deq_busy_i = 1'b0;
        tick();
        enq_valid_i = 1'b0; deq_busy_i = 1'b1;
        checks++;
        if (count_o !== 4'd3 || deq_bundle_o !== 235'h32) begin
            errors++;
            $display("FAIL simul: got count=%0d head=%0h expected 3 32", count_o, deq_bundle_o);
        end
        exp_q = '{235'h32, 235'h33, 235'h34};
        deq_busy_i = 1'b0;
        foreach (exp_q[j]) begin
            checks++;
            if (deq_valid_o !== 1'b1 || deq_bundle_o !== exp_q[j]) begin
                errors++;
                $display("FAIL simul_order: got valid=%b bundle=%0h expected 1 %0h",
                         deq_valid_o, deq_bundle_o, exp_q[j]);
            end
            tick();
        end
    endtask

    task automatic test_async_reset();
        deq_busy_i = 1'b1; enq_valid_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            enq_bundle_i = BW'(32'h70 + i);
            tick();
        end
        enq_valid_i = 1'b0;
        checks++;
        if (count_o !== 4'd5) begin
            errors++; $display("FAIL async_pre: got count=%0d expected 5", count_o);
        end
        #2;
        reset_ni = 1'b0;
        #1;
        checks++;
        if (count_o !== 4'd0 || deq_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got count=%0d valid=%b expected 0 0", count_o, deq_valid_o);
        end
        #1;
        reset_ni = 1'b1;
        tick();
    endtask

    initial begin
        checks = 0; errors = 0;
        reset_ni = 1'b0; flush_i = 1'b0; enq_valid_i = 1'b0; enq_ins1_valid_i = 1'b0;
        enq_bundle_i = '0; deq_busy_i = 1'b0;
        #12;
        test_reset();
        @(negedge cpu_clock_i);
        reset_ni = 1'b1;
        tick();
        test_single();
        test_fill();
        test_stream();
        test_flush_full();
        test_simultaneous();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
